mux_bist_ctrl: RTL and testbench
================================

MUX_BIST_CTRL -- requirements
Module: mux_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of wait cycles between driving a vector and sampling mut_out (range 0..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low; the single clock is clk.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins a test run.
REQ-005 SHALL have port abort  input  1  synchronous stop of a running test.
REQ-006 SHALL have port mut_out  input  1  output of the 4:1 mux under test.
REQ-007 SHALL have ports mut_a, mut_b, mut_c, mut_d  output  1 each  data inputs driven to the mux under test.
REQ-008 SHALL have port mut_sel  output  2  select driven to the mux under test.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at the end of a completed run.
REQ-011 SHALL have port pass  output  1  high after a completed run with zero failures.
REQ-012 SHALL have port fault_indicator  output  1  sticky, set on the first mismatch.
REQ-013 SHALL have port fail_count  output  7  number of mismatching vectors, 0..64.
REQ-014 SHALL have port first_fail_vec  output  6  index of the first mismatching vector.
REQ-015 SHALL have port signature  output  8  MISR signature (see Configuration).

Function
REQ-016 SHALL apply exactly 64 vectors, v = 0..63, in ascending order, mapped as {mut_sel, mut_d, mut_c, mut_b, mut_a} = v.
REQ-017 SHALL compute the expected value as a/b/c/d for sel 00/01/10/11 respectively.
REQ-018 SHALL use FSM states IDLE, APPLY, WAIT, CHECK, DONE.
REQ-019 SHALL transition IDLE->APPLY on start; APPLY lasts 1 cycle; WAIT lasts SETTLE_CYCLES cycles (skipped if 0); CHECK lasts 1 cycle.
REQ-020 SHALL, from CHECK, go to APPLY with v+1 if v<63, else to DONE; DONE lasts 1 cycle, then the FSM returns to IDLE.
REQ-021 SHALL take 64*(2+SETTLE_CYCLES) cycles from the first APPLY to the last CHECK (192 cycles for the default).
REQ-022 SHALL hold the mut_* outputs stable from APPLY through CHECK of each vector, and drive 0 in IDLE.
REQ-023 SHALL, in CHECK on a mismatch: increment fail_count, set fault_indicator, and load first_fail_vec only if fault_indicator was previously 0.
REQ-024 SHALL assert busy in APPLY, WAIT, CHECK and DONE; done is high only in DONE.
REQ-025 SHALL set pass = (fail_count==0) in DONE and hold it until the next accepted start.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL clear fail_count, fault_indicator, first_fail_vec, pass and signature on an accepted start.
REQ-028 SHALL, on abort while busy, return to IDLE next cycle with no done pulse and pass=0, keeping the fault results accumulated so far; abort has priority over start in the same cycle.

Reset
REQ-029 SHALL, while rst_n=0, force the state to IDLE and all outputs to 0, asynchronously, including during a run.

Configuration
REQ-030 SHALL, with MUX_BIST_MISR_EN defined, shift mut_out into an 8-bit MISR on each CHECK, using polynomial x^8+x^4+x^3+x^2+1 and seed 0xFF loaded on an accepted start.
REQ-031 SHALL, without MUX_BIST_MISR_EN, keep the signature port and tie it to 0.

Structure
REQ-032 SHALL place the FSM state enum, NUM_VECTORS=64, MISR_POLY and MISR_SEED in the shared package mux_bist_pkg.
REQ-033 SHALL implement the MISR as the sub-module mux_bist_misr, instantiated only under MUX_BIST_MISR_EN.

Verification
REQ-034 SHALL cover: ideal mux model, SETTLE_CYCLES=1 -> done after 192+ cycles, pass=1, fail_count=0, fault_indicator=0.
REQ-035 SHALL cover: mut_out stuck-at-0 -> fail_count=32, first_fail_vec=1, pass=0.
REQ-036 SHALL cover: mut_out stuck-at-1 -> fail_count=32, first_fail_vec=0, fault_indicator=1.
REQ-037 SHALL cover: sel=01 routed to c instead of b -> fault_indicator=1, first_fail_vec=18.
REQ-038 SHALL cover: rst_n low while v=10 -> all outputs 0 immediately; a subsequent start reruns from v=0.
REQ-039 SHALL cover: a start pulse mid-run is ignored (run length unchanged); abort at v=5 -> busy=0 next cycle, no done pulse.

Source files
------------

// File: rtl/mux_bist_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : mux_bist_pkg                                           |
// | Purpose : Shared FSM encoding, vector count and MISR constants   |
// |           for the 4:1 mux BIST controller.                       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mux_bist_pkg;

  localparam int         NUM_VECTORS = 64;
  // x^8 + x^4 + x^3 + x^2 + 1, the x^8 term being implicit in the shift
  localparam logic [7:0] MISR_POLY   = 8'h1D;
  localparam logic [7:0] MISR_SEED   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } bist_state_t;

  // Golden 4:1 mux response for a packed {sel, d, c, b, a} vector.
  function automatic logic mux_expect(input logic [5:0] vec);
    logic [3:0] data;
    data = vec[3:0];
    return data[vec[5:4]];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_bist_misr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : mux_bist_misr                                          |
// | Purpose : 8-bit single-input MISR compacting the mux response;   |
// |           only instantiated when MUX_BIST_MISR_EN is defined.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mux_bist_misr
  import mux_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load,
  input  logic       shift_en,
  input  logic       din,
  output logic [7:0] signature
);

  logic [7:0] r_sig;
  logic [7:0] w_sig_next;

  // Galois form: feedback from the MSB folds the polynomial taps in.
  always_comb begin
    w_sig_next    = {r_sig[6:0], 1'b0} ^ (r_sig[7] ? MISR_POLY : 8'h00);
    w_sig_next[0] = w_sig_next[0] ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= 8'h00;
    end else if (seed_load) begin
      r_sig <= MISR_SEED;
    end else if (shift_en) begin
      r_sig <= w_sig_next;
    end
  end

  assign signature = r_sig;

endmodule
`default_nettype wire

// File: rtl/mux_bist_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : mux_bist_ctrl                                          |
// | Purpose : Exhaustive 64-vector BIST of a 4:1 mux with fail       |
// |           count, first-fail capture and optional MISR signature  |
// |           (enabled by defining MUX_BIST_MISR_EN).                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mux_bist_ctrl
  import mux_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       mut_out,
  output logic       mut_a,
  output logic       mut_b,
  output logic       mut_c,
  output logic       mut_d,
  output logic [1:0] mut_sel,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fault_indicator,
  output logic [6:0] fail_count,
  output logic [5:0] first_fail_vec,
  output logic [7:0] signature
);

  bist_state_t r_state;
  bist_state_t w_state_next;

  logic [5:0] r_vec;
  logic [3:0] r_wait;
  logic       r_pass;
  logic       r_fault;
  logic [6:0] r_fail_count;
  logic [5:0] r_first_fail;

  logic w_start_ok;
  logic w_abort_ok;
  logic w_last_vec;
  logic w_wait_done;
  logic w_check;
  logic w_mismatch;

  // Abort wins over a simultaneous start, even from IDLE.
  assign w_start_ok  = (r_state == IDLE) && start && !abort;
  assign w_abort_ok  = (r_state != IDLE) && abort;
  assign w_last_vec  = (r_vec == 6'(NUM_VECTORS - 1));
  assign w_wait_done = (r_wait == 4'(SETTLE_CYCLES - 1));
  // An aborted CHECK cycle does not count as a completed comparison.
  assign w_check     = (r_state == CHECK) && !abort;
  assign w_mismatch  = (mut_out != mux_expect(r_vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_abort_ok) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_start_ok) w_state_next = APPLY;
        APPLY:   w_state_next = (SETTLE_CYCLES == 0) ? CHECK : WAIT;
        WAIT:    if (w_wait_done) w_state_next = CHECK;
        CHECK:   w_state_next = w_last_vec ? DONE : APPLY;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    {mut_sel, mut_d, mut_c, mut_b, mut_a} = 6'd0;
    case (r_state)
      APPLY, WAIT, CHECK: begin
        busy = 1'b1;
        {mut_sel, mut_d, mut_c, mut_b, mut_a} = r_vec;
      end
      DONE: begin
        busy = 1'b1;
        done = !abort;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec  <= 6'd0;
      r_wait <= 4'd0;
    end else begin
      if (w_start_ok) begin
        r_vec <= 6'd0;
      end else if (w_check && !w_last_vec) begin
        r_vec <= r_vec + 6'd1;
      end
      r_wait <= (r_state == WAIT) ? r_wait + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass       <= 1'b0;
      r_fault      <= 1'b0;
      r_fail_count <= 7'd0;
      r_first_fail <= 6'd0;
    end else if (w_start_ok) begin
      r_pass       <= 1'b0;
      r_fault      <= 1'b0;
      r_fail_count <= 7'd0;
      r_first_fail <= 6'd0;
    end else if (w_abort_ok) begin
      r_pass <= 1'b0;
    end else if (w_check) begin
      if (w_mismatch) begin
        r_fail_count <= r_fail_count + 7'd1;
        r_fault      <= 1'b1;
        if (!r_fault) begin
          r_first_fail <= r_vec;
        end
      end
      // Includes the final vector's own result so pass is valid in DONE.
      if (w_last_vec) begin
        r_pass <= (r_fail_count == 7'd0) && !w_mismatch;
      end
    end
  end

  assign pass            = r_pass;
  assign fault_indicator = r_fault;
  assign fail_count      = r_fail_count;
  assign first_fail_vec  = r_first_fail;

`ifdef MUX_BIST_MISR_EN
  mux_bist_misr u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (w_start_ok),
    .shift_en  (w_check),
    .din       (mut_out),
    .signature (signature)
  );
`else
  assign signature = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_bist_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_mux_bist_ctrl                                       |
// | Purpose : Self-checking bench for mux_bist_ctrl: faulty-mux      |
// |           models, cycle-indexed reference model, directed runs.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mux_bist_ctrl;

  localparam int SETTLE  = 1;
  localparam int PERIOD  = 2 + SETTLE;
  localparam int RUN_LEN = 64 * PERIOD;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       mut_out;
  logic       mut_a, mut_b, mut_c, mut_d;
  logic [1:0] mut_sel;
  logic       busy, done, pass, fault_indicator;
  logic [6:0] fail_count;
  logic [5:0] first_fail_vec;
  logic [7:0] signature;

  int   mode;
  logic noise;
  int   n_checks = 0;
  int   n_errors = 0;

  mux_bist_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .mut_out         (mut_out),
    .mut_a           (mut_a),
    .mut_b           (mut_b),
    .mut_c           (mut_c),
    .mut_d           (mut_d),
    .mut_sel         (mut_sel),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fault_indicator (fault_indicator),
    .fail_count      (fail_count),
    .first_fail_vec  (first_fail_vec),
    .signature       (signature)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mode 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 sel=01 routed to c, 4 random noise.
  function automatic logic mut_model(input int md, input logic [5:0] v, input logic nz);
    logic [3:0] din;
    logic [1:0] sel;
    din = v[3:0];
    sel = v[5:4];
    case (md)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return (sel == 2'd1) ? din[2] : din[sel];
      4:       return din[sel] ^ nz;
      default: return din[sel];
    endcase
  endfunction

  function automatic logic ideal_mux(input logic [5:0] v);
    case (v[5:4])
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return v[3];
    endcase
  endfunction

  always_comb mut_out = mut_model(mode, {mut_sel, mut_d, mut_c, mut_b, mut_a}, noise);

  initial begin
    noise = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      noise = ($urandom_range(0, 5) == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: a run is a cycle index k from the first APPLY; vector k/PERIOD,
  // compared on the last cycle of each PERIOD, then one DONE cycle.
  bit         m_run, m_done, m_fault, m_pass;
  int         m_k, m_fail;
  logic [5:0] m_first;
  logic [7:0] m_sig;

  initial begin
    logic [5:0] e_vec;
    logic       e_busy, e_done, obs;
    logic [5:0] v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_run = 0; m_done = 0; m_k = 0; m_fail = 0;
        m_fault = 0; m_first = '0; m_pass = 0; m_sig = '0;
      end
      if (m_run) begin
        e_busy = 1'b1; e_done = 1'b0; e_vec = 6'(m_k / PERIOD);
      end else if (m_done) begin
        e_busy = 1'b1; e_done = !abort; e_vec = 6'd0;
      end else begin
        e_busy = 1'b0; e_done = 1'b0; e_vec = 6'd0;
      end
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("mut_vec", {mut_sel, mut_d, mut_c, mut_b, mut_a}, e_vec);
      check("pass", pass, m_pass);
      check("fault_indicator", fault_indicator, m_fault);
      check("fail_count", fail_count, 32'(m_fail));
      check("first_fail_vec", first_fail_vec, m_first);
      check("signature", signature, m_sig);

      if (rst_n) begin
        if ((m_run || m_done) && abort) begin
          m_run = 0; m_done = 0; m_pass = 0;
        end else if (m_run) begin
          v = 6'(m_k / PERIOD);
          if (m_k % PERIOD == PERIOD - 1) begin
            obs = mut_model(mode, v, noise);
            if (obs != ideal_mux(v)) begin
              if (!m_fault) m_first = v;
              m_fault = 1;
              m_fail++;
            end
`ifdef MUX_BIST_MISR_EN
            m_sig = {m_sig[6:0], 1'b0} ^ (m_sig[7] ? 8'h1D : 8'h00) ^ {7'd0, obs};
`endif
            if (v == 6'd63) begin
              m_run = 0; m_done = 1; m_pass = (m_fail == 0);
            end
          end
          m_k++;
        end else if (m_done) begin
          m_done = 0;
        end else if (start && !abort) begin
          m_run = 1; m_k = 0; m_fail = 0; m_fault = 0; m_first = '0; m_pass = 0;
`ifdef MUX_BIST_MISR_EN
          m_sig = 8'hFF;
`else
          m_sig = 8'h00;
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int md, input bit mid_start, output int ncyc);
    bit got;
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    ncyc  = 0;
    got   = 0;
    while (ncyc <= RUN_LEN + 20) begin
      if (done) begin
        got = 1;
        break;
      end
      start = mid_start && (ncyc == 10);
      tick();
      ncyc++;
    end
    start = 1'b0;
    if (!got) timeout_fail("run_done_timeout");
  endtask

  task automatic wait_vec(input int target);
    int n;
    n = 0;
    while (({mut_sel, mut_d, mut_c, mut_b, mut_a} != 6'(target) || !busy) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) timeout_fail("wait_vec_timeout");
  endtask

  initial begin
    int  n;
    bit  seen_done;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    repeat (3) tick();
    check("reset_all_zero", {busy, done, pass, fault_indicator, fail_count, first_fail_vec,
                             signature, mut_sel, mut_d, mut_c, mut_b, mut_a}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    run(0, 0, n);
    check("ideal_len", n, RUN_LEN);
    check("ideal_pass", pass, 1);
    check("ideal_fail_count", fail_count, 0);
    check("ideal_fault", fault_indicator, 0);
    repeat (2) tick();

    run(1, 0, n);
    check("sa0_fail_count", fail_count, 32);
    check("sa0_first", first_fail_vec, 1);
    check("sa0_pass", pass, 0);
    repeat (2) tick();

    run(2, 0, n);
    check("sa1_fail_count", fail_count, 32);
    check("sa1_first", first_fail_vec, 0);
    check("sa1_fault", fault_indicator, 1);
    repeat (2) tick();

    run(3, 0, n);
    check("sel01c_fault", fault_indicator, 1);
    check("sel01c_first", first_fail_vec, 18);
    repeat (2) tick();

    run(0, 1, n);
    check("midstart_len", n, RUN_LEN);
    check("midstart_pass", pass, 1);
    repeat (2) tick();

    // Abort during the APPLY cycle of vector 5: vectors 0, 2, 4 have failed under stuck-at-1.
    mode  = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_vec(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_fail_count", fail_count, 3);
    check("abort_first", first_fail_vec, 0);
    check("abort_pass", pass, 0);
    seen_done = 0;
    repeat (10) begin
      tick();
      if (done) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);

    // Asynchronous reset mid-run at vector 10, then a clean rerun.
    mode  = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_vec(10);
    check("pre_reset_fault", fault_indicator, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_zero", {busy, done, pass, fault_indicator, fail_count, first_fail_vec,
                               signature, mut_sel, mut_d, mut_c, mut_b, mut_a}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run(0, 0, n);
    check("rerun_len", n, RUN_LEN);
    check("rerun_pass", pass, 1);
    repeat (2) tick();

    for (int r = 0; r < 6; r++) begin
      mode  = $urandom_range(0, 4);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < RUN_LEN + 20) begin
        start = ($urandom_range(0, 15) == 0);
        abort = ($urandom_range(0, 399) == 0);
        tick();
        n++;
      end
      start = 1'b0;
      abort = 1'b0;
      if (busy) timeout_fail("random_run_timeout");
      repeat (3) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
